// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB requester-port arbiter: FSM state encoding
// and the default requester count.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ISSUE     = 2'd1,
        ARB_WAIT_BUSY = 2'd2,
        ARB_WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int APB_ARB_DEFAULT_NUM_REQ = 4;

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational request picker: scans req starting at index 'start' and
// wrapping around, returning the first asserted bit as a one-hot vector and
// as a binary index. With start tied to zero it is a lowest-index-wins picker.
module apb_rr_picker
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = APB_ARB_DEFAULT_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               valid
);

    logic [IDX_W-1:0] pos;

    // First asserted request at or after 'start', in wrap-around order.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        pos        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = IDX_W'((int'(start) + k) % NUM_REQ);
            if (!valid && req[pos]) begin
                valid       = 1'b1;
                winner[pos] = 1'b1;
                winner_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// Arbiter sharing one APB requester local port among NUM_REQ requesters.
// Build option: define APB_ARB_RR_EN for round-robin arbitration; without it
// the lowest requester index always wins and no pointer register exists.
//
// Handshake: a requester raises req[i] with its we/addr/din and holds them
// until gnt[i] pulses for one cycle; at that grant the arbiter copies the
// slot into m_*, which then stay stable until the next grant. done[i] pulses
// for one cycle when the transfer finishes, with rsp_dout/rsp_err valid in
// that cycle and held until the next done. Towards the APB requester, m_en
// is a single-cycle start pulse issued only while m_busy=0; m_busy high then
// low marks the transfer complete, with m_dout/m_err valid when it drops.
module apb_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ    = APB_ARB_DEFAULT_NUM_REQ,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                               pclk,
    input  logic                               preset,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_din,
    output logic [NUM_REQ-1:0]                 gnt,
    output logic [NUM_REQ-1:0]                 done,
    output logic [DATA_WIDTH-1:0]              rsp_dout,
    output logic                               rsp_err,
    output logic                               m_en,
    output logic [DATA_WIDTH/8-1:0]            m_we,
    output logic [DATA_WIDTH-1:0]              m_addr,
    output logic [DATA_WIDTH-1:0]              m_din,
    input  logic                               m_busy,
    input  logic [DATA_WIDTH-1:0]              m_dout,
    input  logic                               m_err,
    output logic [1:0]                         dbg_state
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(NUM_REQ);

    arb_state_e              state_q, state_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [NUM_REQ-1:0]      owner_q, owner_d;
    logic [STRB_W-1:0]       m_we_q, m_we_d;
    logic [DATA_WIDTH-1:0]   m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0]   m_din_q, m_din_d;
    logic [DATA_WIDTH-1:0]   rsp_dout_q, rsp_dout_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [IDX_W-1:0]        pick_start;
    logic [NUM_REQ-1:0]      pick_onehot;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_valid;

    apb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req),
        .start      (pick_start),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

`ifdef APB_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    assign pick_start = ptr_q;

    // Next search starts just after the requester granted last.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ARB_IDLE && pick_valid) begin
            ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    // Priority pointer register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    assign pick_start = '0;
`endif

    // Next state, grant/done pulses, captured request and captured response.
    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        done_d     = '0;
        owner_d    = owner_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_din_d    = m_din_q;
        rsp_dout_d = rsp_dout_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    gnt_d    = pick_onehot;
                    owner_d  = pick_onehot;
                    m_addr_d = '0;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (IDX_W'(i) == pick_idx) begin
                            m_we_d                    = req_we[i*STRB_W +: STRB_W];
                            m_addr_d[ADDR_WIDTH-1:0]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                            m_din_d                   = req_din[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    state_d = ARB_ISSUE;
                end
            end
            // The start pulse is held back while the port still reports busy.
            ARB_ISSUE: begin
                if (!m_busy) state_d = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
                if (m_busy) state_d = ARB_WAIT_DONE;
            end
            ARB_WAIT_DONE: begin
                if (!m_busy) begin
                    rsp_dout_d = m_dout;
                    rsp_err_d  = m_err;
                    done_d     = owner_q;
                    state_d    = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            owner_q    <= '0;
            m_we_q     <= '0;
            m_addr_q   <= '0;
            m_din_q    <= '0;
            rsp_dout_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            owner_q    <= owner_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_din_q    <= m_din_d;
            rsp_dout_q <= rsp_dout_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign m_en      = (state_q == ARB_ISSUE) && !m_busy;
    assign gnt       = gnt_q;
    assign done      = done_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_din     = m_din_q;
    assign rsp_dout  = rsp_dout_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: a behavioural APB requester-port model, a grant
// order model derived from the arbitration rules, and a scoreboard that
// checks every grant, start pulse and completion.
module tb_apb_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int EW = N + SW + AW + DW;

    logic            pclk;
    logic            preset;
    logic [N-1:0]    req;
    logic [N*SW-1:0] req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_din;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [DW-1:0]   rsp_dout;
    logic            rsp_err;
    logic            m_en;
    logic [SW-1:0]   m_we;
    logic [DW-1:0]   m_addr;
    logic [DW-1:0]   m_din;
    logic            m_busy;
    logic [DW-1:0]   m_dout;
    logic            m_err;
    logic [1:0]      dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_done = 0;
    int n_en = 0;
    int done_cyc = 0;
    int model_ptr = 0;
    bit outstanding = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] cur = '0;
    logic [DW:0]   slv_rsp_q[$];
    logic [DW:0]   mon_rsp;
    int            gnt_log[$];

    bit            slv_force = 0;
    logic [DW-1:0] slv_f_data = '0;
    logic          slv_f_err = 1'b0;
    int            slv_f_wait = 0;
    int            slv_cnt;
    logic [DW-1:0] slv_pend_data;
    logic          slv_pend_err;

    apb_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_din   (req_din),
        .gnt       (gnt),
        .done      (done),
        .rsp_dout  (rsp_dout),
        .rsp_err   (rsp_err),
        .m_en      (m_en),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_din     (m_din),
        .m_busy    (m_busy),
        .m_dout    (m_dout),
        .m_err     (m_err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    // ---------------- APB requester-port model ----------------
    // Start pulse seen -> busy for 2 + wait cycles, then busy drops with data.
    always @(posedge pclk or posedge preset) begin
        if (preset) begin
            m_busy  <= 1'b0;
            slv_cnt <= 0;
            m_dout  <= '0;
            m_err   <= 1'b0;
        end else if (m_busy) begin
            if (slv_cnt == 0) begin
                m_busy <= 1'b0;
                m_dout <= slv_pend_data;
                m_err  <= slv_pend_err;
                slv_rsp_q.push_back({slv_pend_err, slv_pend_data});
            end else begin
                slv_cnt <= slv_cnt - 1;
            end
        end else if (m_en) begin
            m_busy <= 1'b1;
            if (slv_force) begin
                slv_pend_data <= slv_f_data;
                slv_pend_err  <= slv_f_err;
                slv_cnt       <= 1 + slv_f_wait;
            end else begin
                slv_pend_data <= $urandom;
                slv_pend_err  <= 1'($urandom_range(0, 1));
                slv_cnt       <= 1 + int'($urandom_range(0, 3));
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    always @(negedge pclk) begin
        if (!preset) begin
            if (gnt !== '0) begin
                checks++;
                for (int i = 0; i < N; i++) if (gnt[i]) gnt_log.push_back(i);
                if (outstanding) begin
                    errors++;
                    $display("FAIL overlap: gnt %b while a transfer is outstanding", gnt);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_gnt: got %b expected none", gnt);
                end else begin
                    cur = exp_q.pop_front();
                    if (gnt !== cur[EW-1 -: N] || m_we !== cur[AW+DW +: SW] ||
                        m_addr !== DW'(cur[DW +: AW]) || m_din !== cur[0 +: DW]) begin
                        errors++;
                        $display("FAIL grant: got gnt %b we %h addr %h din %h expected gnt %b we %h addr %h din %h",
                                 gnt, m_we, m_addr, m_din, cur[EW-1 -: N], cur[AW+DW +: SW],
                                 cur[DW +: AW], cur[0 +: DW]);
                    end
                end
                outstanding = 1;
            end
            if (m_en) begin
                n_en++;
                checks++;
                if (m_busy || !outstanding || m_we !== cur[AW+DW +: SW] ||
                    m_addr !== DW'(cur[DW +: AW]) || m_din !== cur[0 +: DW]) begin
                    errors++;
                    $display("FAIL m_en: got busy %b outst %0d we %h addr %h din %h expected busy 0 outst 1 we %h addr %h din %h",
                             m_busy, outstanding, m_we, m_addr, m_din, cur[AW+DW +: SW],
                             cur[DW +: AW], cur[0 +: DW]);
                end
            end
            if (done !== '0) begin
                checks++;
                n_done++;
                done_cyc = cyc;
                if (!outstanding || slv_rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got %b expected none", done);
                end else begin
                    mon_rsp = slv_rsp_q.pop_front();
                    if (done !== cur[EW-1 -: N] || rsp_dout !== mon_rsp[DW-1:0] ||
                        rsp_err !== mon_rsp[DW]) begin
                        errors++;
                        $display("FAIL done: got done %b dout %h err %b expected done %b dout %h err %b",
                                 done, rsp_dout, rsp_err, cur[EW-1 -: N], mon_rsp[DW-1:0], mon_rsp[DW]);
                    end
                end
                outstanding = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    // Winner among 'set': round-robin scans from p, fixed priority from 0.
    function automatic int next_winner(input logic [N-1:0] set, input int p);
        int start;
        start = 0;
`ifdef APB_ARB_RR_EN
        start = p;
`else
        if (p < 0) start = 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (set[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [EW-1:0] slot_entry(input int i);
        logic [N-1:0] oh;
        oh = '0;
        oh[i] = 1'b1;
        return {oh, req_we[i*SW +: SW], req_addr[i*AW +: AW], req_din[i*DW +: DW]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_slot(input int i, input logic [SW-1:0] we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        req_we[i*SW +: SW]   = we;
        req_addr[i*AW +: AW] = a;
        req_din[i*DW +: DW]  = d;
    endtask

    // n_held == 0: each member of 'set' is dropped on its grant.
    // n_held  > 0: 'set' is held until n_held grants have been seen.
    task automatic run_batch(input logic [N-1:0] set, input int n_held);
        logic [N-1:0] left;
        int w, target, start_n, g, budget;
        left = set;
        target = 0;
        if (n_held == 0) begin
            while (left != '0) begin
                w = next_winner(left, model_ptr);
                exp_q.push_back(slot_entry(w));
                left[w] = 1'b0;
                model_ptr = (w + 1) % N;
                target++;
            end
        end else begin
            for (int k = 0; k < n_held; k++) begin
                w = next_winner(set, model_ptr);
                exp_q.push_back(slot_entry(w));
                model_ptr = (w + 1) % N;
                target++;
            end
        end
        start_n = n_done;
        g = 0;
        budget = 0;
        req = set;
        while ((n_done - start_n) < target && budget < 60 * target) begin
            @(posedge pclk); #1;
            budget++;
            if (gnt !== '0) begin
                g++;
                if (n_held == 0) req = req & ~gnt;
                else if (g >= n_held) req = '0;
            end
        end
        req = '0;
        checks++;
        if ((n_done - start_n) != target) begin
            errors++;
            $display("FAIL batch_done: got %0d completions expected %0d", n_done - start_n, target);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        req = '1;
        preset = 1'b0;
        #2 preset = 1'b1;
        #1;
        checks++;
        if ({gnt, done, m_en, m_we, m_addr, m_din, rsp_dout, rsp_err, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt %b done %b m_en %b state %0d expected all zero",
                     gnt, done, m_en, dbg_state);
        end
        repeat (3) @(negedge pclk);
        checks++;
        if (gnt !== '0 || m_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got gnt %b m_en %b expected 0 0", gnt, m_en);
        end
        req = '0;
        preset = 1'b0;
        model_ptr = 0;
        @(posedge pclk); #1;
    endtask

    task automatic test_contention();
        int exp_order[5];
        int n;
        for (int i = 0; i < N; i++) set_slot(i, SW'($urandom), AW'($urandom), DW'($urandom));
        slv_force = 1'b0;
        gnt_log.delete();
`ifdef APB_ARB_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
        n = 5;
        run_batch(4'b1111, 5);
`else
        exp_order = '{1, 1, 1, 1, 1};
        n = 4;
        run_batch(4'b1010, 4);
`endif
        for (int k = 0; k < n; k++) begin
            checks++;
            if (k >= gnt_log.size() || gnt_log[k] != exp_order[k]) begin
                errors++;
                $display("FAIL contention_order[%0d]: got %0d expected %0d", k,
                         (k < gnt_log.size()) ? gnt_log[k] : -1, exp_order[k]);
            end
        end
    endtask

    task automatic test_single_read();
        int req_cyc, en0;
        slv_force = 1'b1;
        slv_f_data = 32'hCAFEF00D;
        slv_f_err = 1'b0;
        slv_f_wait = 1;
        set_slot(2, '0, 32'h40, DW'($urandom));
        req_cyc = cyc;
        en0 = n_en;
        run_batch(4'b0100, 0);
        checks++;
        if (n_en - en0 != 1) begin
            errors++;
            $display("FAIL read_m_en_pulses: got %0d expected 1", n_en - en0);
        end
        checks++;
        if (done_cyc - req_cyc != 6) begin
            errors++;
            $display("FAIL read_latency: got %0d expected 6", done_cyc - req_cyc);
        end
        checks++;
        if (rsp_dout !== 32'hCAFEF00D || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL read_rsp: got %h/%b expected cafef00d/0", rsp_dout, rsp_err);
        end
    endtask

    task automatic test_write_error();
        int req_cyc;
        slv_force = 1'b1;
        slv_f_data = '0;
        slv_f_err = 1'b1;
        slv_f_wait = 0;
        set_slot(0, 4'hF, AW'($urandom), 32'h12345678);
        req_cyc = cyc;
        run_batch(4'b0001, 0);
        checks++;
        if (rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL write_err: got %b expected 1", rsp_err);
        end
        checks++;
        if (m_din !== 32'h12345678 || m_we !== 4'hF) begin
            errors++;
            $display("FAIL write_hold: got din %h we %h expected 12345678 f", m_din, m_we);
        end
        checks++;
        if (done_cyc - req_cyc != 5) begin
            errors++;
            $display("FAIL min_latency: got %0d expected 5", done_cyc - req_cyc);
        end
        @(posedge pclk); #1;
        checks++;
        if (rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL rsp_hold: got %b expected 1", rsp_err);
        end
    endtask

    task automatic test_withdrawn();
        int g3, d3, done0, k;
        slv_force = 1'b0;
        set_slot(0, '0, AW'($urandom), DW'($urandom));
        set_slot(3, SW'($urandom), AW'($urandom), DW'($urandom));
        exp_q.push_back(slot_entry(0));
        model_ptr = 1;
        done0 = n_done;
        g3 = 0;
        d3 = 0;
        req = 4'b0001;
        k = 0;
        while (gnt === '0 && k < 20) begin
            @(posedge pclk); #1;
            k++;
        end
        req = '0;
        @(posedge pclk); #1;
        req[3] = 1'b1;
        @(posedge pclk); #1;
        req[3] = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (gnt[3]) g3++;
            if (done[3]) d3++;
            @(posedge pclk); #1;
        end
        checks++;
        if (g3 != 0 || d3 != 0) begin
            errors++;
            $display("FAIL withdrawn: got gnt3 %0d done3 %0d expected 0 0", g3, d3);
        end
        checks++;
        if (n_done - done0 != 1) begin
            errors++;
            $display("FAIL withdrawn_owner_done: got %0d expected 1", n_done - done0);
        end
    endtask

    task automatic test_reset_mid();
        int k, done0, bad;
        slv_force = 1'b1;
        slv_f_data = 32'h5A5A5A5A;
        slv_f_err = 1'b0;
        slv_f_wait = 6;
        set_slot(1, 4'h3, 32'h100, DW'($urandom));
        exp_q.push_back(slot_entry(1));
        req = 4'b0010;
        k = 0;
        while (gnt === '0 && k < 20) begin
            @(posedge pclk); #1;
            k++;
        end
        req = '0;
        k = 0;
        while (dbg_state !== 2'd3 && k < 20) begin
            @(posedge pclk); #1;
            k++;
        end
        checks++;
        if (dbg_state !== 2'd3 || m_addr !== 32'h100) begin
            errors++;
            $display("FAIL mid_setup: got state %0d addr %h expected 3 00000100", dbg_state, m_addr);
        end
        #2 preset = 1'b1;
        #1;
        checks++;
        if ({gnt, done, m_en, m_we, m_addr, m_din, rsp_dout, rsp_err, dbg_state} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got addr %h din %h rsp %h/%b state %0d expected all zero",
                     m_addr, m_din, rsp_dout, rsp_err, dbg_state);
        end
        bad = 0;
        repeat (2) begin
            @(negedge pclk);
            if (done !== '0) bad++;
        end
        exp_q.delete();
        slv_rsp_q.delete();
        outstanding = 0;
        model_ptr = 0;
        preset = 1'b0;
        done0 = n_done;
        repeat (12) begin
            @(posedge pclk); #1;
            if (done !== '0 || gnt !== '0) bad++;
        end
        checks++;
        if (bad != 0 || n_done != done0) begin
            errors++;
            $display("FAIL abandoned_done: got %0d stray pulses expected 0", bad);
        end
        slv_force = 1'b0;
        set_slot(1, SW'($urandom), AW'($urandom), DW'($urandom));
        run_batch(4'b0010, 0);
    endtask

    task automatic test_random();
        logic [N-1:0] set;
        int held;
        slv_force = 1'b0;
        for (int r = 0; r < 30; r++) begin
            set = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                set_slot(i, ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom),
                         AW'($urandom), DW'($urandom));
            end
            held = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 5)) : 0;
            run_batch(set, held);
        end
        checks++;
        if (exp_q.size() != 0 || outstanding) begin
            errors++;
            $display("FAIL random_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        req = '0;
        req_we = '0;
        req_addr = '0;
        req_din = '0;
        preset = 1'b0;
        test_reset();
        test_contention();
        test_single_read();
        test_write_error();
        test_withdrawn();
        test_reset_mid();
        test_random();
        repeat (3) @(posedge pclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Param NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 Param ADDR_WIDTH, default 32: requester address width; SHALL be <= DATA_WIDTH.
REQ-003 Param DATA_WIDTH, default 32: data width; strobe width is DATA_WIDTH/8.
REQ-004 pclk  in  1  sole clock; all logic on its rising edge.
REQ-005 preset  in  1  asynchronous, active-high reset.
REQ-006 req  in  NUM_REQ  per-requester request; held high until the matching gnt bit.
REQ-007 req_we  in  NUM_REQ*DATA_WIDTH/8  per-requester strobes, slot i at [i*DATA_WIDTH/8 +: DATA_WIDTH/8]; all zero means read.
REQ-008 req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address, flattened likewise.
REQ-009 req_din  in  NUM_REQ*DATA_WIDTH  per-requester write data, flattened likewise.
REQ-010 gnt  out  NUM_REQ  one-hot, one-cycle pulse: request accepted.
REQ-011 done  out  NUM_REQ  one-hot, one-cycle pulse: transfer complete, rsp_* valid this cycle.
REQ-012 rsp_dout  out  DATA_WIDTH  read data of the completed transfer.
REQ-013 rsp_err  out  1  slave error of the completed transfer.
REQ-014 m_en, m_we, m_addr (DATA_WIDTH, zero-extended), m_din  out  drive the APB requester local port.
REQ-015 m_busy, m_dout, m_err  in  from the APB requester local port.

Function
REQ-016 FSM states: ARB_IDLE, ARB_ISSUE, ARB_WAIT_BUSY, ARB_WAIT_DONE.
REQ-017 ARB_IDLE, any req bit high: pick the winner, register its we/addr/din into m_*, pulse gnt[winner], go to ARB_ISSUE next cycle.
REQ-018 ARB_ISSUE: m_en high for exactly one cycle with m_we/m_addr/m_din stable; go to ARB_WAIT_BUSY.
REQ-019 ARB_WAIT_BUSY: m_en low; on m_busy=1 go to ARB_WAIT_DONE.
REQ-020 ARB_WAIT_DONE: on m_busy=0, register m_dout and m_err into rsp_*, pulse done[owner], and return to ARB_IDLE in the same cycle.
REQ-021 m_en SHALL never be asserted unless m_busy=0; back-to-back transfers always pass through ARB_IDLE.
REQ-022 Minimum request-to-done latency is 5 cycles plus APB wait states; no second grant before the prior done.
REQ-023 m_we/m_addr/m_din hold their values from grant until the next grant.
REQ-024 A req bit deasserted before its grant is dropped silently; req changes after grant have no effect on the transfer in flight.
REQ-025 rsp_dout/rsp_err hold until the next done.

Reset
REQ-026 preset high forces ARB_IDLE, priority pointer to 0, and all outputs to 0 immediately, including mid-transfer.
REQ-027 A transfer in flight at reset is abandoned, with no done; the system resets the APB requester on the same event.

Configuration
REQ-028 With APB_ARB_RR_EN defined: round-robin; the search starts at (last winner + 1) mod NUM_REQ, and the pointer updates on each grant.
REQ-029 Without APB_ARB_RR_EN: fixed priority, lowest index wins, and no pointer register exists.

Structure
REQ-030 Package apb_arb_pkg holds the FSM state enum and the default NUM_REQ constant.
REQ-031 Sub-module apb_rr_picker is a combinational picker: inputs req and start pointer, outputs one-hot winner and index; the arbiter instantiates it once.

Verification
REQ-032 Single read: req[2]=1, addr 0x40, we=0; the slave returns 0xCAFEF00D with pready after 1 wait state. Expect gnt[2], one m_en pulse, then done[2] with rsp_dout=0xCAFEF00D and rsp_err=0.
REQ-033 Write error: req[0] with we=0xF, din=0x12345678; slave pslverr=1. Expect done[0] with rsp_err=1, and m_din=0x12345678 during the transfer.
REQ-034 Contention, RR: req=4'b1111 held, pointer 0. Expect gnt order 0,1,2,3,0; never two transfers overlap.
REQ-035 Contention, fixed (macro off): req=4'b1010 held. Expect only requester 1 to be granted, repeatedly.
REQ-036 Reset mid-transfer: assert preset in ARB_WAIT_DONE. Expect all outputs 0 immediately, no done pulse, and a fresh grant after release.
REQ-037 Withdrawn request: req[3] pulsed for 1 cycle while another transfer is in flight. Expect no gnt[3] and no done[3].
